// File: rtl/period_pkg.sv
// Shared constants and state encoding for the period sample packer.
package period_pkg;

    localparam int c_SAMPLE_W    = 8;
    localparam int c_NUM_SAMPLES = 16;
    localparam int c_PERIOD_W    = c_SAMPLE_W * c_NUM_SAMPLES;
    localparam int c_CNT_W       = $clog2(c_NUM_SAMPLES) + 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/period_sample_packer_if.sv
// Sample-in / period-word-out stream bundle for period_sample_packer.
`default_nettype none

interface period_sample_packer_if
    import period_pkg::*;
#(
    parameter int SAMPLE_W    = c_SAMPLE_W,
    parameter int NUM_SAMPLES = c_NUM_SAMPLES
);
    localparam int CNT_W = $clog2(NUM_SAMPLES) + 1;

    logic                            s_valid;
    logic                            s_ready;
    logic [SAMPLE_W-1:0]             s_data;
    logic                            s_last;
    logic                            m_valid;
    logic                            m_ready;
    logic [SAMPLE_W*NUM_SAMPLES-1:0] m_data;
    logic [CNT_W-1:0]                m_count;

    // slave: the packer's view; master: the environment driving samples and taking words
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );

endinterface

`default_nettype wire

// File: rtl/period_sample_packer.sv
// Packs signed samples into one period word (lane 0 = first sample).
// Optional early close on s_last when PERIOD_PACK_FLUSH_EN is defined.
`default_nettype none

module period_sample_packer
    import period_pkg::*;
#(
    parameter int SAMPLE_W    = c_SAMPLE_W,
    parameter int NUM_SAMPLES = c_NUM_SAMPLES
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    period_sample_packer_if.slave  io_bus
);

    localparam int PERIOD_W = SAMPLE_W * NUM_SAMPLES;
    localparam int LANE_W   = $clog2(NUM_SAMPLES);
    localparam int CNT_W    = LANE_W + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [LANE_W-1:0]   r_lane;
    logic [PERIOD_W-1:0] r_buf;
    logic [PERIOD_W-1:0] r_out_data;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic                r_out_valid;
    logic                r_rdy;

    logic                w_accept;
    logic                w_flush;
    logic                w_close;
    logic                w_drain;
    logic                w_out_free;
    logic                w_load_direct;
    logic                w_load_hold;
    logic                w_park;
    logic [CNT_W-1:0]    w_lane_cnt;
    logic [PERIOD_W-1:0] w_buf_merged;

`ifdef PERIOD_PACK_FLUSH_EN
    assign w_flush = io_bus.s_last;
`else
    logic w_unused_last;
    assign w_flush       = 1'b0;
    assign w_unused_last = io_bus.s_last;
`endif

    // s_ready is a register, so it never depends on s_valid
    assign w_accept   = io_bus.s_valid & r_rdy;
    assign w_close    = w_accept & ((r_lane == LANE_W'(NUM_SAMPLES - 1)) | w_flush);
    assign w_drain    = r_out_valid & io_bus.m_ready;
    assign w_out_free = ~r_out_valid | io_bus.m_ready;
    assign w_lane_cnt = {1'b0, r_lane} + CNT_W'(1);

    always_comb begin
        w_buf_merged = r_buf;
        w_buf_merged[r_lane*SAMPLE_W +: SAMPLE_W] = io_bus.s_data;
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_direct = 1'b0;
        w_load_hold   = 1'b0;
        w_park        = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_close) begin
                    if (w_out_free) begin
                        w_load_direct = 1'b1;
                    end else begin
                        w_park       = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_drain) begin
                    w_load_hold  = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy       <= 1'b0;
            r_lane      <= '0;
            r_buf       <= '0;
            r_hold_cnt  <= '0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_rdy <= (w_state_next == ST_FILL);

            if (w_accept) begin
                r_lane <= w_close ? '0 : r_lane + LANE_W'(1);
            end

            // Buffer is cleared on every hand-off so short periods carry zero upper lanes
            if (w_load_direct || w_load_hold) begin
                r_buf <= '0;
            end else if (w_accept) begin
                r_buf <= w_buf_merged;
            end

            if (w_park) begin
                r_hold_cnt <= w_lane_cnt;
            end

            if (w_load_direct) begin
                r_out_data  <= w_buf_merged;
                r_out_cnt   <= w_lane_cnt;
                r_out_valid <= 1'b1;
            end else if (w_load_hold) begin
                r_out_data  <= r_buf;
                r_out_cnt   <= r_hold_cnt;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_bus.s_ready = r_rdy;
    assign io_bus.m_valid = r_out_valid;
    assign io_bus.m_data  = r_out_data;
    assign io_bus.m_count = r_out_cnt;

endmodule

`default_nettype wire

// File: doc/period_sample_packer.md
PERIOD_SAMPLE_PACKER -- requirements
Module: period_sample_packer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, meaning signed sample width in bits.
REQ-002 SHALL have parameter NUM_SAMPLES, default 16, meaning samples per period word (power of two).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, meaning the sample is offered.
REQ-006 SHALL have port s_ready, output, 1, meaning the packer accepts the sample.
REQ-007 SHALL have port s_data, input, SAMPLE_W, meaning the signed two's-complement sample.
REQ-008 SHALL have port s_last, input, 1, meaning the sample closes the period early (see REQ-024).
REQ-009 SHALL have port m_valid, output, 1, meaning a period word is presented.
REQ-010 SHALL have port m_ready, input, 1, meaning the consumer (abs-sum stage) takes the word.
REQ-011 SHALL have port m_data, output, SAMPLE_W*NUM_SAMPLES, meaning the packed period word.
REQ-012 SHALL have port m_count, output, $clog2(NUM_SAMPLES)+1, meaning the number of valid lanes in m_data.

Function
REQ-013 SHALL complete a sample transfer on a cycle with s_valid&&s_ready, and a word transfer on a cycle with m_valid&&m_ready.
REQ-014 SHALL place the k-th accepted sample of a period (k=0..NUM_SAMPLES-1) at m_data[SAMPLE_W*k +: SAMPLE_W], so the first sample goes in the LSB lane.
REQ-015 SHALL hold a fill buffer, a lane counter (0..NUM_SAMPLES-1) and a separate output register.
REQ-016 SHALL use states FILL (buffer accepting samples) and HOLD (buffer complete, output register occupied and not draining).
REQ-017 SHALL, in FILL, store each accepted sample in its lane and increment the counter.
REQ-018 SHALL, when the period-closing sample is accepted, move the buffer to the output register on the same edge and reset the counter to 0, if the output register is empty or drains that cycle; otherwise it SHALL enter HOLD.
REQ-019 SHALL, in HOLD, deassert s_ready and move the buffer to the output register on the edge where m_ready&&m_valid, returning to FILL.
REQ-020 SHALL assert m_valid the cycle after the period-closing sample is accepted, giving 1-cycle latency.
REQ-021 SHALL keep m_data/m_count stable while m_valid&&!m_ready, and SHALL never drop m_valid without a transfer.
REQ-022 SHALL sustain one sample per cycle indefinitely while m_ready is held high.
REQ-023 SHALL set m_count to NUM_SAMPLES for full periods.
REQ-024 SHALL, with the feature enabled, treat s_last as closing the period at lane k, with m_count=k+1 and lanes above k zero; s_last on lane NUM_SAMPLES-1 SHALL be identical to a normal full period.
REQ-025 SHALL keep s_ready independent of s_valid (no combinational path from s_valid).

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear m_valid=0, m_data=0, m_count=0, counter=0, buffer=0, state=FILL, s_ready=0 while asserted.
REQ-027 SHALL assert s_ready on the first clk edge after rst_n deasserts.
REQ-028 SHALL discard any partial period and any pending word when reset occurs mid-operation; no word SHALL be emitted for it.

Configuration
REQ-029 SHALL use macro PERIOD_PACK_FLUSH_EN: when defined, s_last behaves per REQ-024; when undefined, s_last is ignored, every word is full, and m_count is constant NUM_SAMPLES when m_valid.

Structure
REQ-030 SHALL place the constants SAMPLE_W default, NUM_SAMPLES default, PERIOD_W = SAMPLE_W*NUM_SAMPLES, the count width and the state enum typedef in shared package period_pkg.
REQ-031 SHALL be a single module with no sub-module; the consumer connects m_data directly to the period abs-sum input.

Verification
REQ-032 SHALL cover a continuous stream: samples 0x01..0x10 with m_ready=1 -> m_data=0x100F...0201 (lane0=0x01), m_valid one cycle after the 16th sample, m_count=16.
REQ-033 SHALL cover backpressure: 32 samples with m_ready=0 -> first word held stable, s_ready low after the 32nd sample (HOLD); raising m_ready -> two words in order, no sample lost.
REQ-034 SHALL cover signed extremes: lanes alternating 0x80/0x7F -> m_data bit-exact, and the downstream abs-sum equals 16*127+8 = 2040.
REQ-035 SHALL cover flush (PERIOD_PACK_FLUSH_EN): s_last on the 5th sample -> m_count=5, lanes 5..15 zero, next period starting at lane 0.
REQ-036 SHALL cover reset: rst_n pulsed low after 7 samples -> outputs 0 immediately, and the next 16 samples form one clean word.
REQ-037 SHALL cover the macro undefined: s_last asserted on every sample -> only full 16-lane words are produced.
